// File: rtl/selector41_arbiter.sv
// Round-robin arbiter that schedules four requesters onto one 4-to-1, 4-bit selector and registers the chosen word.
// Define SEL41_FIXED_PRIO_EN to replace the rotating scan with a fixed 0,1,2,3 priority order.
module selector41_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic [3:0] iReq,
  input  logic [3:0] iC0,
  input  logic [3:0] iC1,
  input  logic [3:0] iC2,
  input  logic [3:0] iC3,
  output logic [3:0] oGnt,
  output logic       oS1,
  output logic       oS0,
  output logic [3:0] oZ,
  output logic       oValid,
  output logic       oDbgState
);

  // Handshake: no back-pressure. oValid=1 means oZ carries a word captured on the
  // previous edge; the consumer must take it that cycle or lose it.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  arbState_t        state, stateNext;
  logic [3:0]       gnt, gntNext;
  logic [1:0]       idx, idxNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [3:0]       z, zNext;
  logic             valid, validNext;

  logic       transfer, lastWord, tenureEnd;
  logic [3:0] selData;
  logic [1:0] idleBase, endBase;
  logic       idleFound, endFound;
  logic [1:0] idleIdx, endIdx;

  // Scan base+1, base+2, base+3, base: base itself has the lowest priority.
  function automatic logic [2:0] scanFrom(input logic [3:0] req, input logic [1:0] base);
    logic       found;
    logic [1:0] pick;
    logic [1:0] cand;
    found = 1'b0;
    pick  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = base + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return {found, pick};
  endfunction

`ifdef SEL41_FIXED_PRIO_EN
  // A base of 3 makes the rotating scan degenerate to the fixed order 0,1,2,3.
  assign idleBase = 2'd3;
  assign endBase  = 2'd3;
`else
  logic [1:0] ptr;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr <= 2'd3;
    end else if (tenureEnd) begin
      ptr <= idx;
    end
  end

  assign idleBase = ptr;
  assign endBase  = idx;
`endif

  assign {idleFound, idleIdx} = scanFrom(iReq, idleBase);
  assign {endFound, endIdx}   = scanFrom(iReq, endBase);

  assign transfer  = (state == GRANT) && iReq[idx];
  assign lastWord  = (cnt == CNT_W'(MAX_HOLD - 1));
  assign tenureEnd = (state == GRANT) && (!iReq[idx] || lastWord);

  always_comb begin
    selData = iC0;
    case (idx)
      2'd0:    selData = iC0;
      2'd1:    selData = iC1;
      2'd2:    selData = iC2;
      default: selData = iC3;
    endcase
  end

  always_comb begin
    stateNext = state;
    gntNext   = gnt;
    idxNext   = idx;
    cntNext   = cnt;
    zNext     = z;
    validNext = 1'b0;
    case (state)
      IDLE: begin
        if (idleFound) begin
          stateNext = GRANT;
          gntNext   = 4'b0001 << idleIdx;
          idxNext   = idleIdx;
          cntNext   = '0;
        end
      end
      GRANT: begin
        if (transfer) begin
          zNext     = selData;
          validNext = 1'b1;
          cntNext   = cnt + 1'b1;
        end
        // Handover happens on the ending edge itself, so there is no idle bubble.
        if (tenureEnd) begin
          if (endFound) begin
            gntNext = 4'b0001 << endIdx;
            idxNext = endIdx;
            cntNext = '0;
          end else begin
            stateNext = IDLE;
            gntNext   = '0;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state <= IDLE;
      gnt   <= '0;
      idx   <= 2'd0;
      cnt   <= '0;
      z     <= '0;
      valid <= 1'b0;
    end else begin
      state <= stateNext;
      gnt   <= gntNext;
      idx   <= idxNext;
      cnt   <= cntNext;
      z     <= zNext;
      valid <= validNext;
    end
  end

  assign oGnt      = gnt;
  assign oS1       = idx[1];
  assign oS0       = idx[0];
  assign oZ        = z;
  assign oValid    = valid;
  assign oDbgState = state;

endmodule

// File: tb/tb_selector41_arbiter.sv
// Directed bench for selector41_arbiter: reset, single requester, rotation, early release, mid-tenure reset, priority mode.
module tb_selector41_arbiter;

  logic       iClk;
  logic       iRst_n;
  logic [3:0] iReq;
  logic [3:0] iC0, iC1, iC2, iC3;
  logic [3:0] oGnt;
  logic       oS1, oS0;
  logic [3:0] oZ;
  logic       oValid;
  logic       oDbgState;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0] exp_q[$];

  selector41_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iReq      (iReq),
    .iC0       (iC0),
    .iC1       (iC1),
    .iC2       (iC2),
    .iC3       (iC3),
    .oGnt      (oGnt),
    .oS1       (oS1),
    .oS0       (oS0),
    .oZ        (oZ),
    .oValid    (oValid),
    .oDbgState (oDbgState)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Called at the sample point (1 after an edge); finishes well before the next edge.
  task automatic applyReset();
    iRst_n = 1'b0;
    #2;
    iRst_n = 1'b1;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iReq   = 4'hF;
    iC0 = 4'h1; iC1 = 4'h2; iC2 = 4'h3; iC3 = 4'h4;
    #3;
    assertCount++;
    if ({oGnt, oS1, oS0, oZ, oValid} !== 11'd0) begin
      failCount++;
      $display("FAIL reset_outputs: got gnt=%b s=%b%b z=%h v=%b, expected all zero", oGnt, oS1, oS0, oZ, oValid);
    end
    assertCount++;
    if (oDbgState !== 1'b0) begin
      failCount++;
      $display("FAIL reset_state: got %b expected 0", oDbgState);
    end
    iReq = 4'h0;
    #1;
    iRst_n = 1'b1;
    tick();
    assertCount++;
    if (oGnt !== 4'b0000) begin
      failCount++;
      $display("FAIL idle_no_req: got gnt=%b expected 0000", oGnt);
    end
  endtask

  task automatic test_single();
    applyReset();
    iC2  = 4'hA;
    iReq = 4'b0100;
    tick();
    assertCount++;
    if ({oGnt, oS1, oS0, oValid} !== {4'b0100, 2'b10, 1'b0}) begin
      failCount++;
      $display("FAIL single_grant: got gnt=%b s=%b%b v=%b expected gnt=0100 s=10 v=0", oGnt, oS1, oS0, oValid);
    end
    // Four words, then the timeout regrant keeps data flowing on edge 6.
    for (int i = 0; i < 5; i++) begin
      tick();
      assertCount++;
      if ({oGnt, oZ, oValid} !== {4'b0100, 4'hA, 1'b1}) begin
        failCount++;
        $display("FAIL single_data[%0d]: got gnt=%b z=%h v=%b expected gnt=0100 z=a v=1", i, oGnt, oZ, oValid);
      end
    end
    iReq = 4'b0000;
    tick();
    assertCount++;
    if ({oGnt, oS1, oS0, oValid, oDbgState} !== {4'b0000, 2'b10, 1'b0, 1'b0}) begin
      failCount++;
      $display("FAIL single_release: got gnt=%b s=%b%b v=%b st=%b expected gnt=0000 s=10 v=0 st=0",
               oGnt, oS1, oS0, oValid, oDbgState);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] expGnt;
    logic [3:0] expZ;
    applyReset();
    iC0 = 4'h1; iC1 = 4'h2; iC2 = 4'h3; iC3 = 4'h4;
    iReq = 4'hF;
    tick();
    assertCount++;
    if (oGnt !== 4'b0001) begin
      failCount++;
      $display("FAIL rr_first_grant: got %b expected 0001", oGnt);
    end
    for (int t = 0; t < 20; t++) begin
`ifdef SEL41_FIXED_PRIO_EN
      exp_q.push_back(4'h1);
`else
      exp_q.push_back(4'(((t / 4) % 4) + 1));
`endif
    end
    for (int t = 0; t < 20; t++) begin
      tick();
`ifdef SEL41_FIXED_PRIO_EN
      expGnt = 4'b0001;
`else
      expGnt = 4'b0001 << (((t + 1) / 4) % 4);
`endif
      expZ = exp_q.pop_front();
      assertCount++;
      if ({oGnt, oZ, oValid} !== {expGnt, expZ, 1'b1}) begin
        failCount++;
        $display("FAIL rr_step[%0d]: got gnt=%b z=%h v=%b expected gnt=%b z=%h v=1", t, oGnt, oZ, oValid, expGnt, expZ);
      end
    end
    iReq = 4'h0;
    tick();
  endtask

  task automatic test_early_release();
    applyReset();
    iC1  = 4'h5;
    iC3  = 4'h9;
    iReq = 4'b1010;
    tick();
    assertCount++;
    if (oGnt !== 4'b0010) begin
      failCount++;
      $display("FAIL early_grant: got %b expected 0010", oGnt);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      assertCount++;
      if ({oZ, oValid} !== {4'h5, 1'b1}) begin
        failCount++;
        $display("FAIL early_data[%0d]: got z=%h v=%b expected z=5 v=1", i, oZ, oValid);
      end
    end
    iReq = 4'b1000;
    tick();
    assertCount++;
    if ({oGnt, oS1, oS0, oValid} !== {4'b1000, 2'b11, 1'b0}) begin
      failCount++;
      $display("FAIL early_handover: got gnt=%b s=%b%b v=%b expected gnt=1000 s=11 v=0", oGnt, oS1, oS0, oValid);
    end
    tick();
    assertCount++;
    if ({oZ, oValid} !== {4'h9, 1'b1}) begin
      failCount++;
      $display("FAIL early_next_data: got z=%h v=%b expected z=9 v=1", oZ, oValid);
    end
    iReq = 4'h0;
    tick();
  endtask

  task automatic test_mid_reset();
    applyReset();
    iC2  = 4'hA;
    iReq = 4'b0100;
    tick();
    tick();
    #1;
    iRst_n = 1'b0;
    #1;
    assertCount++;
    if ({oGnt, oS1, oS0, oZ, oValid, oDbgState} !== 12'd0) begin
      failCount++;
      $display("FAIL midreset_clear: got gnt=%b s=%b%b z=%h v=%b st=%b expected all zero",
               oGnt, oS1, oS0, oZ, oValid, oDbgState);
    end
    iReq = 4'b0110;
    #1;
    iRst_n = 1'b1;
    tick();
    assertCount++;
    if ({oGnt, oValid} !== {4'b0010, 1'b0}) begin
      failCount++;
      $display("FAIL midreset_regrant: got gnt=%b v=%b expected gnt=0010 v=0", oGnt, oValid);
    end
    iReq = 4'h0;
    tick();
    tick();
  endtask

  task automatic test_prio_mode();
    logic [3:0] expGnt;
    logic [3:0] expZ;
    applyReset();
    iC0  = 4'h3;
    iC3  = 4'hC;
    iReq = 4'b1001;
    tick();
    assertCount++;
    if (oGnt !== 4'b0001) begin
      failCount++;
      $display("FAIL prio_first_grant: got %b expected 0001", oGnt);
    end
    for (int t = 0; t < 16; t++) begin
      tick();
`ifdef SEL41_FIXED_PRIO_EN
      expGnt = 4'b0001;
      expZ   = 4'h3;
`else
      expGnt = (((t + 1) / 4) % 2 == 0) ? 4'b0001 : 4'b1000;
      expZ   = ((t / 4) % 2 == 0) ? 4'h3 : 4'hC;
`endif
      assertCount++;
      if ({oGnt, oZ, oValid} !== {expGnt, expZ, 1'b1}) begin
        failCount++;
        $display("FAIL prio_step[%0d]: got gnt=%b z=%h v=%b expected gnt=%b z=%h v=1", t, oGnt, oZ, oValid, expGnt, expZ);
      end
    end
    iReq = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_mid_reset();
    test_prio_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
